retire_monitor_queue: RTL and testbench

RETIRE_MONITOR_QUEUE -- requirements
Module: retire_monitor_queue

---
 rtl/rv32i_types.sv | 28 ++
 rtl/retire_compact.sv | 25 ++
 rtl/retire_monitor_queue.sv | 118 +++++++++++
 tb/tb_retire_monitor_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I retire-record types and field widths for the retire monitor path.
package rv32i_types;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MASK_W     = XLEN / 8;
    localparam int ORDER_W    = 64;
    // Wide enough for a popcount of up to four retire channels.
    localparam int RANK_W     = 3;

    typedef struct packed {
        logic [XLEN-1:0]       inst;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]       rs1_rdata;
        logic [XLEN-1:0]       rs2_rdata;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rd_wdata;
        logic [XLEN-1:0]       pc_rdata;
        logic [XLEN-1:0]       pc_wdata;
        logic [XLEN-1:0]       mem_addr;
        logic [MASK_W-1:0]     mem_rmask;
        logic [MASK_W-1:0]     mem_wmask;
        logic [XLEN-1:0]       mem_rdata;
        logic [XLEN-1:0]       mem_wdata;
    } rvfi_pkt_t;

endpackage

// File: rtl/retire_compact.sv
// Per-channel rank among valid retire channels (ascending index) and total popcount.
module retire_compact
    import rv32i_types::*;
#(
    parameter int NRET = 2
) (
    input  logic [NRET-1:0]             valid,
    output logic [NRET-1:0][RANK_W-1:0] rank,
    output logic [RANK_W-1:0]           total
);

    logic [RANK_W-1:0] acc;

    // Rank of channel i is the number of valid channels below it.
    always_comb begin
        acc  = '0;
        rank = '0;
        for (int i = 0; i < NRET; i++) begin
            rank[i] = acc;
            acc     = acc + RANK_W'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/retire_monitor_queue.sv
// Multi-channel retire monitor queue: compacts up to NRET retire records per cycle
// into a circular buffer, tags each with a 64-bit retire order, and presents one per cycle.
module retire_monitor_queue
    import rv32i_types::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRET-1:0]          ret_valid,
    input  rvfi_pkt_t [NRET-1:0]     ret_pkt,
    output logic                     ret_ready,
    output logic                     mon_valid,
    input  logic                     mon_ready,
    output logic [ORDER_W-1:0]       mon_order,
    output rvfi_pkt_t                mon_pkt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ORDER_W-1:0] order_ctr_q, order_ctr_d;
    logic               overflow_q, overflow_d;

    logic [ORDER_W-1:0] order_mem_q [DEPTH];
    logic [ORDER_W-1:0] order_mem_d [DEPTH];
    rvfi_pkt_t          pkt_mem_q   [DEPTH];
    rvfi_pkt_t          pkt_mem_d   [DEPTH];

    logic [NRET-1:0][RANK_W-1:0] rank;
    logic [RANK_W-1:0]           k;
    logic [RANK_W-1:0]           k_eff;
    logic [NRET-1:0][PTR_W-1:0]  slot;
    logic                        enq;
    logic                        deq;

    retire_compact #(
        .NRET (NRET)
    ) u_compact (
        .valid (ret_valid),
        .rank  (rank),
        .total (k)
    );

    // Credit comes only from the registered occupancy; a same-cycle pop is not counted.
    assign ret_ready = (DEPTH - int'(count_q)) >= NRET;
    assign mon_valid = (count_q != '0);
    assign enq       = ret_ready && (ret_valid != '0);
    assign deq       = mon_valid && mon_ready;
    assign k_eff     = enq ? k : '0;

    assign mon_order = mon_valid ? order_mem_q[head_q] : '0;
    assign mon_pkt   = mon_valid ? pkt_mem_q[head_q]   : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Slot indices wrap naturally because DEPTH is a power of two.
    always_comb begin
        slot = '0;
        for (int i = 0; i < NRET; i++) begin
            slot[i] = tail_q + PTR_W'(rank[i]);
        end
    end

    always_comb begin
        order_mem_d = order_mem_q;
        pkt_mem_d   = pkt_mem_q;
        if (enq) begin
            for (int i = 0; i < NRET; i++) begin
                if (ret_valid[i]) begin
                    order_mem_d[slot[i]] = order_ctr_q + ORDER_W'(rank[i]);
                    pkt_mem_d[slot[i]]   = ret_pkt[i];
                end
            end
        end
    end

    always_comb begin
        head_d      = head_q + PTR_W'(deq);
        tail_d      = tail_q + PTR_W'(k_eff);
        count_d     = count_q + CNT_W'(k_eff) - CNT_W'(deq);
        order_ctr_d = order_ctr_q + ORDER_W'(k_eff);
        overflow_d  = overflow_q;
        // Whole cycle is dropped when there is no room for a full NRET burst.
        if ((ret_valid != '0) && !ret_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            order_ctr_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            order_ctr_q <= order_ctr_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        order_mem_q <= order_mem_d;
        pkt_mem_q   <= pkt_mem_d;
    end

endmodule

// File: tb/tb_retire_monitor_queue.sv
// Bench for retire_monitor_queue: directed scenarios plus random traffic against a queue model.
module tb_retire_monitor_queue;
    import rv32i_types::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRET-1:0]      ret_valid;
    rvfi_pkt_t [NRET-1:0] ret_pkt;
    logic                 ret_ready;
    logic                 mon_valid;
    logic                 mon_ready;
    logic [63:0]          mon_order;
    rvfi_pkt_t            mon_pkt;
    logic [3:0]           count;
    logic                 overflow;

    retire_monitor_queue #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ret_valid (ret_valid),
        .ret_pkt   (ret_pkt),
        .ret_ready (ret_ready),
        .mon_valid (mon_valid),
        .mon_ready (mon_ready),
        .mon_order (mon_order),
        .mon_pkt   (mon_pkt),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ord;
        rvfi_pkt_t   pkt;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_ord;
    bit          m_ovf;
    int          total = 0;
    int          bad   = 0;

    function automatic rvfi_pkt_t rand_pkt(input logic [31:0] pc);
        logic [319:0] r;
        rvfi_pkt_t    p;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        p = rvfi_pkt_t'(r[$bits(rvfi_pkt_t)-1:0]);
        p.pc_rdata = pc;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        bit          exp_ready;
        logic [63:0] exp_ord;
        rvfi_pkt_t   exp_pkt;
        exp_ready = (DEPTH - mq.size()) >= NRET;
        exp_ord   = (mq.size() != 0) ? mq[0].ord : 64'd0;
        exp_pkt   = (mq.size() != 0) ? mq[0].pkt : '0;
        chk({tag, "_count"},     count, mq.size());
        chk({tag, "_mon_valid"}, mon_valid, mq.size() != 0);
        chk({tag, "_ret_ready"}, ret_ready, exp_ready);
        chk({tag, "_overflow"},  overflow, m_ovf);
        chk({tag, "_mon_order"}, mon_order, exp_ord);
        chk({tag, "_mon_pkt"},   mon_pkt, exp_pkt);
    endtask

    // One clock: drive at the falling edge, advance the model, check just after the rising edge.
    task automatic step(input string tag, input logic [1:0] v, input logic rdy, input logic r,
                        input logic [31:0] pc0, input logic [31:0] pc1);
        rvfi_pkt_t p [NRET];
        bit        room;
        bit        pop;
        @(negedge clk);
        p[0] = rand_pkt(pc0);
        p[1] = rand_pkt(pc1);
        rst       = r;
        ret_valid = v;
        mon_ready = rdy;
        ret_pkt[0] = p[0];
        ret_pkt[1] = p[1];
        if (r) begin
            mq.delete();
            m_ord = 64'd0;
            m_ovf = 1'b0;
        end else begin
            room = (DEPTH - mq.size()) >= NRET;
            pop  = (mq.size() != 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (v != 2'b00) begin
                if (room) begin
                    for (int ch = 0; ch < NRET; ch++) begin
                        if (v[ch]) begin
                            mq.push_back('{ord: m_ord, pkt: p[ch]});
                            m_ord = m_ord + 64'd1;
                        end
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        rst       = 1'b1;
        ret_valid = '0;
        mon_ready = 1'b0;
        ret_pkt   = '0;
        m_ord     = 64'd0;
        m_ovf     = 1'b0;

        // Reset with retire traffic present
        step("rst0", 2'b11, 1'b1, 1'b1, 32'h0, 32'h0);
        step("rst1", 2'b11, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("rst_count", count, 0);
        chk("rst_ready", ret_ready, 1);

        // Dual retire, ascending order
        step("r31a", 2'b11, 1'b0, 1'b0, 32'h60, 32'h64);
        chk("r31_ord0", mon_order, 64'd0);
        chk("r31_pc0", mon_pkt.pc_rdata, 32'h60);
        chk("r31_cnt", count, 2);
        step("r31b", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("r31_ord1", mon_order, 64'd1);
        chk("r31_pc1", mon_pkt.pc_rdata, 32'h64);
        step("r31c", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);

        // Compaction of channel 1 alone
        step("r32r", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        step("r32a", 2'b10, 1'b0, 1'b0, 32'h0, 32'h68);
        chk("r32_ord", mon_order, 64'd0);
        chk("r32_pc", mon_pkt.pc_rdata, 32'h68);
        chk("r32_cnt", count, 1);
        step("r32b", 2'b01, 1'b1, 1'b0, 32'h6c, 32'h0);
        chk("r32_ord_next", mon_order, 64'd1);
        chk("r32_pc_next", mon_pkt.pc_rdata, 32'h6c);
        step("r32c", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);

        // Fill to full, then a dropped burst
        step("r33r", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step("r33f", 2'b11, 1'b0, 1'b0, 32'h100 + 8*i, 32'h104 + 8*i);
        chk("r33_cnt_full", count, 8);
        chk("r33_ready_lo", ret_ready, 0);
        step("r33d", 2'b11, 1'b0, 1'b0, 32'h200, 32'h204);
        chk("r33_ovf", overflow, 1);
        chk("r33_cnt_hold", count, 8);
        for (int i = 0; i < 8; i++) step("r33e", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        step("r33n", 2'b01, 1'b0, 1'b0, 32'h300, 32'h0);
        chk("r33_ord_after_drop", mon_order, 64'd8);

        // Simultaneous push/pop and pointer wrap
        step("r34r", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step("r34f", 2'b11, 1'b0, 1'b0, 32'h400 + 8*i, 32'h404 + 8*i);
        step("r34s", 2'b01, 1'b1, 1'b0, 32'h430, 32'h0);
        chk("r34_cnt_same", count, 6);
        step("r34w", 2'b11, 1'b1, 1'b0, 32'h438, 32'h43c);
        chk("r34_cnt7", count, 7);
        step("r34x", 2'b01, 1'b1, 1'b0, 32'h440, 32'h0);
        chk("r34_cnt7_drop", count, 6);
        for (int i = 0; i < 7; i++) step("r34d", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);

        // Order counter wrap
        step("r35r", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        force dut.order_ctr_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ord = 64'hFFFF_FFFF_FFFF_FFFF;
        step("r35a", 2'b11, 1'b0, 1'b0, 32'h500, 32'h504);
        chk("r35_ord_max", mon_order, 64'hFFFF_FFFF_FFFF_FFFF);
        release dut.order_ctr_q;
        step("r35b", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("r35_ord_wrap", mon_order, 64'd0);
        chk("r35_pc_wrap", mon_pkt.pc_rdata, 32'h504);

        // Reset dominates a busy, overflowed queue
        step("r36r", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step("r36f", 2'b11, 1'b0, 1'b0, 32'h600 + 8*i, 32'h604 + 8*i);
        for (int i = 0; i < 3; i++) step("r36d", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("r36_cnt5", count, 5);
        step("r36x", 2'b11, 1'b1, 1'b1, 32'h700, 32'h704);
        chk("r36_cnt0", count, 0);
        chk("r36_valid0", mon_valid, 0);
        chk("r36_ovf0", overflow, 0);
        step("r36n", 2'b10, 1'b0, 1'b0, 32'h0, 32'h708);
        chk("r36_ord0", mon_order, 64'd0);

        // Random traffic with shifting consumer pressure
        for (int i = 0; i < 400; i++) begin
            logic [1:0] v;
            logic       rdy;
            logic       r;
            v   = 2'($urandom_range(0, 3));
            rdy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 79) == 0);
            step("rand", v, rdy, r, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
